// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and MEM-stage loads/stores.
// Each access is split into byte transfers; read bytes are assembled little-endian.
module mem_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  n;
    logic [31:0] wbuf;
    logic [31:0] rbuf;

    logic unused_addr_hi;
    assign unused_addr_hi = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            n         <= 3'd0;
            wbuf      <= 32'd0;
            rbuf      <= 32'd0;
            if_done   <= 1'b0;
            if_inst   <= 32'd0;
            mem_done  <= 1'b0;
            mem_rdata <= 32'd0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'd0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // the cycle carrying a done pulse is a forced turnaround
                    if (if_done || mem_done) begin
                        state <= IDLE;
                    end else if (mem_req) begin
                        ram_a <= mem_addr[ADDR_W-1:0];
                        cnt   <= 3'd0;
                        rbuf  <= 32'd0;
                        n     <= (mem_len == 2'd0) ? 3'd1 :
                                 (mem_len == 2'd1) ? 3'd2 : 3'd4;
                        if (mem_we) begin
                            state    <= MEM_WR;
                            ram_wr   <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                            wbuf     <= mem_wdata >> 8;
                        end else begin
                            state <= MEM_RD;
                        end
                    end else if (if_req && !if_flush) begin
                        state <= IF_RD;
                        ram_a <= if_addr[ADDR_W-1:0];
                        cnt   <= 3'd0;
                        rbuf  <= 32'd0;
                        n     <= 3'd4;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state == IF_RD && if_flush) begin
                        state <= IDLE;
                    end else if (cnt != n) begin
                        rbuf[{cnt[1:0], 3'b000} +: 8] <= ram_din;
                        cnt   <= cnt + 3'd1;
                        ram_a <= ram_a + ADDR_W'(1);
                    end else begin
                        state <= IDLE;
                        if (state == IF_RD) begin
                            if_done <= 1'b1;
                            if_inst <= rbuf;
                        end else begin
                            mem_done  <= 1'b1;
                            mem_rdata <= rbuf;
                        end
                    end
                end
                MEM_WR: begin
                    if (cnt + 3'd1 != n) begin
                        cnt      <= cnt + 3'd1;
                        ram_a    <= ram_a + ADDR_W'(1);
                        ram_dout <= wbuf[7:0];
                        wbuf     <= wbuf >> 8;
                    end else begin
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
